// File: rtl/y86_pkg.sv
//==============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 encodings: icodes, register ids, ALU ops, CC type.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package y86_pkg;

    localparam logic [3:0] c_I_HALT   = 4'h0;
    localparam logic [3:0] c_I_NOP    = 4'h1;
    localparam logic [3:0] c_I_RRMOVQ = 4'h2;
    localparam logic [3:0] c_I_IRMOVQ = 4'h3;
    localparam logic [3:0] c_I_RMMOVQ = 4'h4;
    localparam logic [3:0] c_I_MRMOVQ = 4'h5;
    localparam logic [3:0] c_I_OPQ    = 4'h6;
    localparam logic [3:0] c_I_JXX    = 4'h7;
    localparam logic [3:0] c_I_CALL   = 4'h8;
    localparam logic [3:0] c_I_RET    = 4'h9;
    localparam logic [3:0] c_I_PUSHQ  = 4'hA;
    localparam logic [3:0] c_I_POPQ   = 4'hB;

    localparam logic [3:0] c_RSP   = 4'h4;
    localparam logic [3:0] c_RNONE = 4'hF;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_e;

    localparam logic [3:0] c_C_ALWAYS = 4'd0;
    localparam logic [3:0] c_C_LE     = 4'd1;
    localparam logic [3:0] c_C_L      = 4'd2;
    localparam logic [3:0] c_C_E      = 4'd3;
    localparam logic [3:0] c_C_NE     = 4'd4;
    localparam logic [3:0] c_C_GE     = 4'd5;
    localparam logic [3:0] c_C_G      = 4'd6;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    function automatic logic need_regids(input logic [3:0] icode);
        return (icode == c_I_RRMOVQ) || (icode == c_I_IRMOVQ) || (icode == c_I_RMMOVQ) ||
               (icode == c_I_MRMOVQ) || (icode == c_I_OPQ)    || (icode == c_I_PUSHQ)  ||
               (icode == c_I_POPQ);
    endfunction

    function automatic logic need_valc(input logic [3:0] icode);
        return (icode == c_I_IRMOVQ) || (icode == c_I_RMMOVQ) || (icode == c_I_MRMOVQ) ||
               (icode == c_I_JXX)    || (icode == c_I_CALL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/y86_alu_cc.sv
//==============================================================================
// Module      : y86_alu_cc
// Description : 64-bit Y86 ALU, next-flag generation and branch/move condition.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module y86_alu_cc
    import y86_pkg::*;
(
    input  logic [63:0] alu_a,
    input  logic [63:0] alu_b,
    input  alu_op_e     alu_op,
    input  logic        cond_en,
    input  logic [3:0]  cond_fun,
    input  cc_t         cc_q,
    output logic [63:0] val_e,
    output cc_t         cc_new,
    output logic        cnd
);

    logic w_lt;

    always_comb begin
        val_e = 64'd0;
        case (alu_op)
            ALU_ADD: val_e = alu_b + alu_a;
            ALU_SUB: val_e = alu_b - alu_a;
            ALU_AND: val_e = alu_b & alu_a;
            ALU_XOR: val_e = alu_b ^ alu_a;
            default: val_e = 64'd0;
        endcase
    end

    always_comb begin
        cc_new.zf = (val_e == 64'd0);
        cc_new.sf = val_e[63];
        cc_new.of = 1'b0;
        case (alu_op)
            ALU_ADD: cc_new.of = (alu_a[63] == alu_b[63]) && (val_e[63] != alu_a[63]);
            ALU_SUB: cc_new.of = (alu_a[63] != alu_b[63]) && (val_e[63] != alu_b[63]);
            default: cc_new.of = 1'b0;
        endcase
    end

    // Conditions read the committed flags, not the ones being produced now.
    assign w_lt = cc_q.sf ^ cc_q.of;

    always_comb begin
        cnd = 1'b0;
        if (cond_en) begin
            case (cond_fun)
                c_C_ALWAYS: cnd = 1'b1;
                c_C_LE:     cnd = w_lt | cc_q.zf;
                c_C_L:      cnd = w_lt;
                c_C_E:      cnd = cc_q.zf;
                c_C_NE:     cnd = ~cc_q.zf;
                c_C_GE:     cnd = ~w_lt;
                c_C_G:      cnd = ~w_lt & ~cc_q.zf;
                default:    cnd = 1'b0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/y86_seq_fde_core.sv
//==============================================================================
// Module      : y86_seq_fde_core
// Description : SEQ Y86-64 fetch/decode/execute with register file and CC.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module y86_seq_fde_core
    import y86_pkg::*;
#(
    parameter int unsigned IMEM_SIZE = 20481
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] PC,
    input  logic [0:79] instr,
    input  logic [63:0] valM,
    input  logic [3:0]  dbg_sel,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [63:0] valE,
    output logic        cnd,
    output logic        zero_f,
    output logic        sign_f,
    output logic        overflow_f,
    output logic        valid_instr,
    output logic        ins_mem_error,
    output logic        halt,
    output logic [63:0] dbg_data
);

    logic [63:0] r_regs_q [0:14];
    logic [63:0] w_regs_d [0:14];
    cc_t         r_cc_q;
    cc_t         w_cc_d;
    cc_t         w_cc_new;

    logic [7:0]  w_byte [0:9];
    logic        w_need_regids;
    logic        w_need_valc;
    logic [3:0]  w_len;
    logic [3:0]  w_src_a;
    logic [3:0]  w_src_b;
    logic [3:0]  w_dst_e;
    logic [3:0]  w_dst_m;
    logic [63:0] w_alu_a;
    logic [63:0] w_alu_b;
    alu_op_e     w_alu_op;
    logic        w_cond_en;

    // Byte 0 of the window sits in the most significant (lowest-numbered) bits.
    always_comb begin
        for (int k = 0; k < 10; k++) begin
            w_byte[k] = instr[8*k +: 8];
        end
    end

    assign icode         = w_byte[0][7:4];
    assign ifun          = w_byte[0][3:0];
    assign w_need_regids = need_regids(icode);
    assign w_need_valc   = need_valc(icode);
    assign rA            = w_need_regids ? w_byte[1][7:4] : c_RNONE;
    assign rB            = w_need_regids ? w_byte[1][3:0] : c_RNONE;
    assign w_len         = 4'd1 + {3'd0, w_need_regids} + {w_need_valc, 3'd0};
    assign valP          = PC + {60'd0, w_len};

    always_comb begin
        valC = 64'd0;
        if ((icode == c_I_IRMOVQ) || (icode == c_I_RMMOVQ) || (icode == c_I_MRMOVQ)) begin
            for (int k = 0; k < 8; k++) valC[8*k +: 8] = w_byte[k+2];
        end else if ((icode == c_I_JXX) || (icode == c_I_CALL)) begin
            for (int k = 0; k < 8; k++) valC[8*k +: 8] = w_byte[k+1];
        end
    end

    always_comb begin
        valid_instr = 1'b0;
        if (icode == c_I_OPQ)
            valid_instr = (ifun <= 4'd3);
        else if ((icode == c_I_RRMOVQ) || (icode == c_I_JXX))
            valid_instr = (ifun <= 4'd6);
        else if (icode <= c_I_POPQ)
            valid_instr = (ifun == 4'd0);
    end

    // Widened by one bit so a PC near 2^64 cannot wrap past the bound.
    assign ins_mem_error = ({1'b0, PC} + {61'd0, w_len}) > 65'(IMEM_SIZE);
    assign halt          = (icode == c_I_HALT) | ~valid_instr | ins_mem_error;

    always_comb begin
        case (icode)
            c_I_RRMOVQ, c_I_RMMOVQ, c_I_OPQ, c_I_PUSHQ: w_src_a = rA;
            c_I_RET, c_I_POPQ:                          w_src_a = c_RSP;
            default:                                    w_src_a = c_RNONE;
        endcase
        case (icode)
            c_I_RMMOVQ, c_I_MRMOVQ, c_I_OPQ:              w_src_b = rB;
            c_I_CALL, c_I_RET, c_I_PUSHQ, c_I_POPQ:       w_src_b = c_RSP;
            default:                                      w_src_b = c_RNONE;
        endcase
    end

    assign valA     = (w_src_a == c_RNONE) ? 64'd0 : r_regs_q[w_src_a];
    assign valB     = (w_src_b == c_RNONE) ? 64'd0 : r_regs_q[w_src_b];
    assign dbg_data = (dbg_sel == c_RNONE) ? 64'd0 : r_regs_q[dbg_sel];

    always_comb begin
        case (icode)
            c_I_RRMOVQ, c_I_OPQ:                 w_alu_a = valA;
            c_I_IRMOVQ, c_I_RMMOVQ, c_I_MRMOVQ:  w_alu_a = valC;
            c_I_CALL, c_I_PUSHQ:                 w_alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
            c_I_RET, c_I_POPQ:                   w_alu_a = 64'd8;
            default:                             w_alu_a = 64'd0;
        endcase
    end

    assign w_alu_b   = ((icode == c_I_RRMOVQ) || (icode == c_I_IRMOVQ)) ? 64'd0 : valB;
    assign w_alu_op  = (icode == c_I_OPQ) ? alu_op_e'(ifun[1:0]) : ALU_ADD;
    assign w_cond_en = (icode == c_I_RRMOVQ) || (icode == c_I_JXX);

    y86_alu_cc u_alu_cc (
        .alu_a    (w_alu_a),
        .alu_b    (w_alu_b),
        .alu_op   (w_alu_op),
        .cond_en  (w_cond_en),
        .cond_fun (ifun),
        .cc_q     (r_cc_q),
        .val_e    (valE),
        .cc_new   (w_cc_new),
        .cnd      (cnd)
    );

    always_comb begin
        case (icode)
            c_I_RRMOVQ:                             w_dst_e = cnd ? rB : c_RNONE;
            c_I_IRMOVQ, c_I_OPQ:                    w_dst_e = rB;
            c_I_CALL, c_I_RET, c_I_PUSHQ, c_I_POPQ: w_dst_e = c_RSP;
            default:                                w_dst_e = c_RNONE;
        endcase
        w_dst_m = ((icode == c_I_MRMOVQ) || (icode == c_I_POPQ)) ? rA : c_RNONE;
    end

    // valM is applied last so it wins when both ports target the same register.
    always_comb begin
        for (int i = 0; i < 15; i++) w_regs_d[i] = r_regs_q[i];
        w_cc_d = r_cc_q;
        if (!halt) begin
            if (w_dst_e != c_RNONE) w_regs_d[w_dst_e] = valE;
            if (w_dst_m != c_RNONE) w_regs_d[w_dst_m] = valM;
            if (icode == c_I_OPQ)   w_cc_d = w_cc_new;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) r_regs_q[i] <= 64'd0;
            r_cc_q <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
        end else begin
            for (int i = 0; i < 15; i++) r_regs_q[i] <= w_regs_d[i];
            r_cc_q <= w_cc_d;
        end
    end

    assign zero_f     = r_cc_q.zf;
    assign sign_f     = r_cc_q.sf;
    assign overflow_f = r_cc_q.of;

endmodule

`default_nettype wire

// File: tb/tb_y86_seq_fde_core.sv
//==============================================================================
// Module      : tb_y86_seq_fde_core
// Description : Directed scoreboard bench for the SEQ fetch/decode/execute core.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_y86_seq_fde_core;

    localparam int unsigned IMEM_SIZE = 20481;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] PC;
    logic [0:79] instr;
    logic [63:0] valM;
    logic [3:0]  dbg_sel;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, valA, valB, valE, dbg_data;
    logic        cnd, zero_f, sign_f, overflow_f, valid_instr, ins_mem_error, halt;

    y86_seq_fde_core #(.IMEM_SIZE(IMEM_SIZE)) dut (
        .clk(clk), .rst_n(rst_n), .PC(PC), .instr(instr), .valM(valM), .dbg_sel(dbg_sel),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
        .valA(valA), .valB(valB), .valE(valE), .cnd(cnd), .zero_f(zero_f),
        .sign_f(sign_f), .overflow_f(overflow_f), .valid_instr(valid_instr),
        .ins_mem_error(ins_mem_error), .halt(halt), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    function automatic logic [0:79] enc(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic has_c, input int c_at,
                                        input logic [63:0] c);
        logic [0:79] w;
        w = '0;
        w[0:7] = b0;
        w[8:15] = b1;
        if (has_c) for (int k = 0; k < 8; k++) w[8*(c_at+k) +: 8] = c[8*k +: 8];
        return w;
    endfunction

    function automatic logic [0:79] i_irmovq(input logic [3:0] rb, input logic [63:0] v);
        return enc(8'h30, {4'hF, rb}, 1'b1, 2, v);
    endfunction

    function automatic logic [0:79] i_rr(input logic [7:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb);
        return enc(op, {ra, rb}, 1'b0, 0, 64'd0);
    endfunction

    function automatic logic [0:79] i_dest(input logic [7:0] op, input logic [63:0] d);
        return enc(op, d[7:0], 1'b1, 1, d);
    endfunction

    task automatic drive(input logic [63:0] pc, input logic [0:79] ins, input logic [63:0] vm);
        @(negedge clk);
        PC    = pc;
        instr = ins;
        valM  = vm;
        #1;
    endtask

    // After the commit edge, park the core on a halt so nothing else writes.
    task automatic tick();
        @(posedge clk);
        #1;
        PC    = 64'd0;
        instr = '0;
        valM  = 64'd0;
    endtask

    task automatic rd(input logic [3:0] sel);
        dbg_sel = sel;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; PC = 64'd0; instr = '0; valM = 64'd0; dbg_sel = 4'd0;
        tick();
        tick();
        rst_n = 1'b1;

        rd(4'd3); push("reset_rbx", 64'd0); chk(dbg_data);
        push("reset_zf", 64'd1); chk({63'd0, zero_f});
        push("reset_sf", 64'd0); chk({63'd0, sign_f});
        push("reset_of", 64'd0); chk({63'd0, overflow_f});

        // irmovq $0x100,%rbx ; irmovq $0x200,%rdx ; addq %rdx,%rbx ; halt
        drive(64'd0, i_irmovq(4'd3, 64'h100), 64'd0);
        push("irm1_valp", 64'd10); chk(valP);
        push("irm1_valc", 64'h100); chk(valC);
        push("irm1_ra", 64'hF); chk({60'd0, rA});
        tick();
        drive(64'd10, i_irmovq(4'd2, 64'h200), 64'd0);
        push("irm2_valp", 64'd20); chk(valP);
        tick();
        drive(64'd20, i_rr(8'h60, 4'd2, 4'd3), 64'd0);
        push("add_valp", 64'd22); chk(valP);
        push("add_vale", 64'h300); chk(valE);
        tick();
        rd(4'd3); push("add_rbx", 64'h300); chk(dbg_data);
        push("add_cc", 64'b000); chk({61'd0, zero_f, sign_f, overflow_f});
        drive(64'd22, '0, 64'd0);
        push("halt_byte22", 64'd1); chk({63'd0, halt});

        // subq with negative result
        drive(64'd0, i_irmovq(4'd3, 64'd4), 64'd0); tick();
        drive(64'd10, i_irmovq(4'd2, 64'h600), 64'd0); tick();
        drive(64'd20, i_rr(8'h61, 4'd2, 4'd3), 64'd0);
        push("sub_vale", 64'hFFFF_FFFF_FFFF_FA04); chk(valE);
        tick();
        push("sub_cc", 64'b010); chk({61'd0, zero_f, sign_f, overflow_f});

        // cmovl taken, cmove not taken
        drive(64'd22, i_rr(8'h22, 4'd3, 4'd4), 64'd0);
        push("cmovl_cnd", 64'd1); chk({63'd0, cnd});
        tick();
        rd(4'd4); push("cmovl_rsp", 64'hFFFF_FFFF_FFFF_FA04); chk(dbg_data);
        drive(64'd24, i_rr(8'h23, 4'd3, 4'd1), 64'd0);
        push("cmove_cnd", 64'd0); chk({63'd0, cnd});
        tick();
        rd(4'd1); push("cmove_rcx", 64'd0); chk(dbg_data);

        // signed overflow on add
        drive(64'd0, i_irmovq(4'd0, 64'h7FFF_FFFF_FFFF_FFFF), 64'd0); tick();
        drive(64'd10, i_irmovq(4'd1, 64'd1), 64'd0); tick();
        drive(64'd20, i_rr(8'h60, 4'd1, 4'd0), 64'd0);
        push("ovf_vale", 64'h8000_0000_0000_0000); chk(valE);
        tick();
        push("ovf_cc", 64'b011); chk({61'd0, zero_f, sign_f, overflow_f});

        drive(64'd30, i_dest(8'h70, 64'h27), 64'd0);
        push("jmp_cnd", 64'd1); chk({63'd0, cnd});
        push("jmp_valp", 64'd39); chk(valP);
        push("jmp_valc", 64'h27); chk(valC);
        drive(64'd30, i_dest(8'h72, 64'h27), 64'd0);
        push("jl_cnd", 64'd0); chk({63'd0, cnd});
        drive(64'd30, i_dest(8'h76, 64'h27), 64'd0);
        push("jg_cnd", 64'd1); chk({63'd0, cnd});

        // call pushes return address slot
        drive(64'd0, i_irmovq(4'd4, 64'h100), 64'd0); tick();
        drive(64'd40, i_dest(8'h80, 64'h80), 64'd0);
        push("call_vale", 64'hF8); chk(valE);
        push("call_valp", 64'd49); chk(valP);
        tick();
        rd(4'd4); push("call_rsp", 64'hF8); chk(dbg_data);

        // popq %rsp: memory value beats the incremented pointer
        drive(64'd49, i_rr(8'hB0, 4'd4, 4'hF), 64'h55);
        push("pop_vale", 64'h100); chk(valE);
        tick();
        rd(4'd4); push("pop_rsp", 64'h55); chk(dbg_data);

        // illegal encodings change nothing
        drive(64'd51, enc(8'hC0, 8'h00, 1'b0, 0, 64'd0), 64'd0);
        push("icodeC_valid", 64'd0); chk({63'd0, valid_instr});
        push("icodeC_halt", 64'd1); chk({63'd0, halt});
        tick();
        drive(64'd51, i_rr(8'h64, 4'd4, 4'd4), 64'd0);
        push("opq_bad_valid", 64'd0); chk({63'd0, valid_instr});
        tick();
        rd(4'd4); push("illegal_rsp", 64'h55); chk(dbg_data);
        push("illegal_cc", 64'b011); chk({61'd0, zero_f, sign_f, overflow_f});

        // fetch bounds at the top of instruction memory
        drive(64'(IMEM_SIZE - 1), i_irmovq(4'd0, 64'd7), 64'd0);
        push("memerr_flag", 64'd1); chk({63'd0, ins_mem_error});
        push("memerr_halt", 64'd1); chk({63'd0, halt});
        tick();
        rd(4'd0); push("memerr_rax", 64'h8000_0000_0000_0000); chk(dbg_data);
        drive(64'(IMEM_SIZE - 10), i_irmovq(4'd0, 64'd7), 64'd0);
        push("edge_flag", 64'd0); chk({63'd0, ins_mem_error});
        tick();
        rd(4'd0); push("edge_rax", 64'd7); chk(dbg_data);
        rd(4'hF); push("dbg_rnone", 64'd0); chk(dbg_data);

        // reset mid-program overrides a pending add
        drive(64'd20, i_rr(8'h61, 4'd2, 4'd3), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rd(4'd3); push("rst_rbx", 64'd0); chk(dbg_data);
        rd(4'd4); push("rst_rsp", 64'd0); chk(dbg_data);
        rd(4'd0); push("rst_rax", 64'd0); chk(dbg_data);
        push("rst_cc", 64'b100); chk({61'd0, zero_f, sign_f, overflow_f});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/y86_seq_fde_core.md
Name: y86_seq_fde_core

Overview:
Fetch, decode/writeback and execute stages of the single-cycle (SEQ) Y86-64 processor, merged into one block. It takes the current PC, a 10-byte instruction window and valM from the memory stage. It produces the decoded fields, operands, ALU result, branch/move condition and valP for the PC-update logic. It holds the 15-entry register file and the condition-code register.

Parameters:
IMEM_SIZE, 20481, instruction memory size in bytes, used for the fetch bounds check.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset.
PC  in  64  address of the current instruction.
instr  in  80 [0:79]  bytes PC..PC+9; bits [0:7] = byte 0.
valM  in  64  memory-stage read data, written back to dstM.
dbg_sel  in  4  register-file debug read select.
icode, ifun, rA, rB  out  4 each  decoded fields.
valC  out  64  constant word.
valP  out  64  fall-through PC.
valA, valB  out  64  register operands.
valE  out  64  ALU result.
cnd  out  1  condition result.
zero_f, sign_f, overflow_f  out  1 each  registered CC.
valid_instr  out  1  instruction is legal.
ins_mem_error  out  1  fetch address out of range.
halt  out  1  stop request.
dbg_data  out  64  regfile[dbg_sel]; 0 when dbg_sel = F.

Behaviour:
- All outputs except CC and dbg_data are combinational from PC, instr, register state and CC.
- Fetch:
  - icode = byte0[7:4], ifun = byte0[3:0].
  - need_regids for icode 2,3,4,5,6,A,B: rA = byte1[7:4], rB = byte1[3:0]; otherwise rA = rB = F.
  - valC is little-endian: bytes 2..9 for icode 3,4,5; bytes 1..8 for icode 7,8; otherwise 0.
  - valP = PC + 1 + need_regids + 8*need_valC.
- valid_instr:
  - icode <= B.
  - ifun <= 3 for icode 6; ifun <= 6 for icode 2 and 7; ifun = 0 for all other icodes.
- ins_mem_error = (PC + instruction length > IMEM_SIZE).
- halt = (icode == 0) | ~valid_instr | ins_mem_error.
- Decode, srcA:
  - rA for icode 2, 4, 6, A.
  - RSP (4) for icode 9, B.
  - otherwise F.
- Decode, srcB:
  - rB for icode 4, 5, 6.
  - RSP for icode 8, 9, A, B.
  - otherwise F.
  - Reading register F yields 0.
- Execute, aluA:
  - valA for icode 2, 6.
  - valC for icode 3, 4, 5.
  - -8 for icode 8, A.
  - +8 for icode 9, B.
- Execute, aluB: valB, except 0 for icode 2 and 3.
- ALU op = ifun for OPq, otherwise ADD. Op codes: 0 ADD, 1 SUB (aluB - aluA), 2 AND, 3 XOR. Arithmetic is 64-bit, wraps with no carry out.
- Flags computed from the current ALU result:
  - ZF = (valE == 0).
  - SF = valE[63].
  - OF for ADD = (aluA[63] == aluB[63]) & (valE[63] != aluA[63]).
  - OF for SUB = (aluA[63] != aluB[63]) & (valE[63] != aluB[63]).
  - OF = 0 for AND and XOR.
- CC register loads those flags on a rising edge only when icode = 6 and halt = 0.
- cnd uses the registered CC and applies only to icode 2 and 7; cnd = 0 for all other icodes. Conditions by ifun:
  - 0: always true.
  - 1 (le): (SF^OF) | ZF.
  - 2 (l): SF^OF.
  - 3 (e): ZF.
  - 4 (ne): ~ZF.
  - 5 (ge): ~(SF^OF).
  - 6 (g): ~(SF^OF) & ~ZF.
- Writeback happens on the rising edge when rst_n = 1 and halt = 0.
- dstE:
  - rB for icode 2 (only if cnd), 3, 6.
  - RSP for icode 8, 9, A, B.
  - otherwise F.
- dstM = rA for icode 5 and B; otherwise F.
- Writes to register F are discarded.
- If dstE == dstM, the valM write wins (popq %rsp).
- Reset, when rst_n = 0 at an edge:
  - all 15 registers = 0.
  - ZF = 1, SF = 0, OF = 0.
  - Reset overrides any pending writeback or CC update in the same cycle.
- Halted, invalid or faulting instruction: no register write, no CC update; outputs are still driven.

Decomposition:
- Package y86_pkg:
  - icode constants (HALT..POPQ).
  - register ids RSP = 4, RNONE = F.
  - ALU op codes.
  - condition function codes.
- One natural sub-module: y86_alu_cc, containing the ALU, flag generation and condition evaluation.
- Fetch split, register file and control muxes stay in the top block.

Test Plan:
- irmovq $0x100,%rbx; irmovq $0x200,%rdx; addq %rdx,%rbx.
  -> rbx = 0x300; ZF = 0, SF = 0, OF = 0; valP sequence 10, 20, 22; halt at byte 22.
- rbx = 4, rdx = 0x600; subq %rdx,%rbx.
  -> valE = 0xFFFF_FFFF_FFFF_FA04; SF = 1, ZF = 0, OF = 0.
- Then cmovl %rbx,%rsp.
  -> cnd = 1, rsp = rbx. cmove in the same state gives cnd = 0 and no write.
- Overflow: add 0x7FFF_FFFF_FFFF_FFFF + 1.
  -> OF = 1, SF = 1.
- jmp with valC = 0x27 at PC = 30.
  -> cnd = 1, valP = 39.
- call with rsp = 0x100.
  -> valE = 0xF8; rsp = 0xF8 after the edge.
- popq %rsp with valM = 0x55.
  -> rsp = 0x55.
- icode = C: valid_instr = 0, halt = 1, no state change.
- PC = IMEM_SIZE - 1 with irmovq: ins_mem_error = 1.
- Assert rst_n = 0 mid-program: all registers 0, ZF = 1 after the edge.
